// File: rtl/i2s_ser.sv
// I2S master transmitter: one 64-bit frame buffer feeding bck/lrck/sdata in Philips format.
// Outputs are registered and change on the clk where bck falls; ready = buffer empty, no other backpressure.
module i2s_ser #(
    parameter int BCK_HALF = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        en,
    input  logic [63:0] data,
    input  logic        valid,
    output logic        ready,
    input  logic [1:0]  bitnum,
    output logic        bck,
    output logic        lrck,
    output logic        sdata,
    output logic        underrun
);

    localparam logic [1:0] BITNUM_B16 = 2'd0;
    localparam logic [1:0] BITNUM_B24 = 2'd1;
    localparam logic [1:0] BITNUM_B32 = 2'd2;

    localparam int             CW       = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam logic [CW-1:0]  DIV_LAST = CW'(BCK_HALF - 1);

    logic [CW-1:0] div_q, div_d;
    logic          bck_q, bck_d;
    logic [5:0]    k_q, k_d;
    logic          lrck_q, lrck_d;
    logic          sdata_q, sdata_d;
    logic          under_q, under_d;
    logic [63:0]   frm_q, frm_d;
    logic [63:0]   buf_q, buf_d;
    logic          full_q, full_d;

    logic          div_wrap;
    logic          fall;
    logic          accept;
    logic [5:0]    k_next;

    function automatic logic [31:0] mask_word(input logic [31:0] w, input logic [1:0] bn);
        case (bn)
            BITNUM_B16: return w & 32'hFFFF_0000;
            BITNUM_B24: return w & 32'hFFFF_FF00;
            BITNUM_B32: return w;
            default:    return w;
        endcase
    endfunction

    always_comb begin
        div_d    = div_q;
        bck_d    = bck_q;
        k_d      = k_q;
        lrck_d   = lrck_q;
        sdata_d  = sdata_q;
        under_d  = 1'b0;
        frm_d    = frm_q;
        buf_d    = buf_q;
        full_d   = full_q;

        div_wrap = (div_q == DIV_LAST);
        fall     = en && div_wrap && bck_q;
        accept   = valid && !full_q;
        k_next   = k_q + 6'd1;

        if (!en) begin
            div_d   = '0;
            bck_d   = 1'b0;
            k_d     = 6'd63;
            lrck_d  = 1'b1;
            sdata_d = 1'b0;
            frm_d   = '0;
        end else begin
            div_d = div_wrap ? '0 : div_q + CW'(1);
            if (div_wrap) begin
                bck_d = ~bck_q;
            end
            if (fall) begin
                k_d    = k_next;
                lrck_d = k_next[5];
                if (k_next == 6'd0) begin
                    // Slot 0 still carries the previous frame's right-channel LSB.
                    sdata_d = frm_q[0];
                    if (full_q) begin
                        frm_d  = {mask_word(buf_q[63:32], bitnum), mask_word(buf_q[31:0], bitnum)};
                        full_d = 1'b0;
                    end else begin
                        frm_d   = '0;
                        under_d = 1'b1;
                    end
                end else begin
                    // Slots 1..63 map to frame bit 64-k for both channels.
                    sdata_d = frm_q[6'd0 - k_next];
                end
            end
        end

        if (accept) begin
            full_d = 1'b1;
            buf_d  = data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_q   <= '0;
            bck_q   <= 1'b0;
            k_q     <= 6'd63;
            lrck_q  <= 1'b1;
            sdata_q <= 1'b0;
            under_q <= 1'b0;
            frm_q   <= '0;
            buf_q   <= '0;
            full_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            bck_q   <= bck_d;
            k_q     <= k_d;
            lrck_q  <= lrck_d;
            sdata_q <= sdata_d;
            under_q <= under_d;
            frm_q   <= frm_d;
            buf_q   <= buf_d;
            full_q  <= full_d;
        end
    end

    assign ready    = !full_q;
    assign bck      = bck_q;
    assign lrck     = lrck_q;
    assign sdata    = sdata_q;
    assign underrun = under_q;

endmodule

// File: tb/tb_i2s_ser.sv
// Bench for i2s_ser: time-based reference model, per-cycle compare, and captured-frame literal checks.
module tb_i2s_ser;

    localparam int H = 2;
    localparam logic [1:0] B16 = 2'd0;
    localparam logic [1:0] B24 = 2'd1;
    localparam logic [1:0] B32 = 2'd2;

    localparam logic [63:0] F0 = 64'hA5000001_80000003;
    localparam logic [63:0] FA = 64'hFFFFFFFF_FFFFFFFF;
    localparam logic [63:0] D0 = 64'h12345678_9ABCDEF1;
    localparam logic [63:0] D1 = 64'hDEADBEEF_00000001;
    localparam logic [63:0] D2 = 64'h80000000_7FFFFFFF;
    localparam logic [63:0] D3 = 64'hC0FFEE00_13579BDF;
    localparam logic [63:0] D4 = 64'h0F0F0F0F_F0F0F0F0;
    localparam logic [63:0] D5 = 64'h5555AAAA_AAAA5555;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [63:0] data;
    logic        valid;
    logic        ready;
    logic [1:0]  bitnum;
    logic        bck;
    logic        lrck;
    logic        sdata;
    logic        underrun;

    i2s_ser #(.BCK_HALF(H)) dut (
        .clk(clk), .resetn(resetn), .en(en), .data(data), .valid(valid), .ready(ready),
        .bitnum(bitnum), .bck(bck), .lrck(lrck), .sdata(sdata), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything follows from clk count since start plus a one-deep buffer.
    int          m_t = 0;
    bit          m_full = 0;
    logic [63:0] m_buf = '0;
    logic [63:0] m_cur = '0;
    bit          m_prev0 = 0;
    bit          m_under = 0;
    bit          m_fall = 0;

    function automatic int kof(input int t);
        int f;
        f = t / (2 * H);
        return (f == 0) ? 63 : (f - 1) % 64;
    endfunction

    function automatic logic [63:0] maskf(input logic [63:0] w, input logic [1:0] bn);
        if (bn == B16) return w & 64'hFFFF0000_FFFF0000;
        if (bn == B24) return w & 64'hFFFFFF00_FFFFFF00;
        return w;
    endfunction

    initial forever begin
        bit acc;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            m_t = 0; m_full = 0; m_buf = '0; m_cur = '0;
            m_prev0 = 0; m_under = 0; m_fall = 0;
        end else begin
            acc     = valid && !m_full;
            m_under = 0;
            m_fall  = 0;
            if (!en) begin
                m_t = 0; m_cur = '0; m_prev0 = 0;
            end else begin
                m_t++;
                if (m_t % (2 * H) == 0) begin
                    m_fall = 1;
                    if (kof(m_t) == 0) begin
                        m_prev0 = m_cur[0];
                        if (m_full) begin
                            m_cur  = maskf(m_buf, bitnum);
                            m_full = 0;
                        end else begin
                            m_cur   = '0;
                            m_under = 1;
                        end
                    end
                end
            end
            if (acc) begin
                m_full = 1;
                m_buf  = data;
            end
        end
    end

    // Per-cycle compare plus reassembly of complete frames from the serial stream.
    int          cap_n = -1000;
    logic [63:0] cap_w = '0;
    bit          cap_u = 0;
    logic [63:0] got_f[$];
    bit          got_u[$];

    initial forever begin
        int  k;
        int  f;
        bit  e_sd;
        @(negedge clk);
        f = m_t / (2 * H);
        k = kof(m_t);
        e_sd = (f == 0) ? 1'b0 : ((k == 0) ? m_prev0 : m_cur[64 - k]);
        chk("bck", bck, (m_t / H) % 2);
        chk("lrck", lrck, (k >= 32) ? 1 : 0);
        chk("sdata", sdata, e_sd);
        chk("ready", ready, !m_full);
        chk("underrun", underrun, m_under);
        if (m_t == 0) begin
            cap_n = -1000;
        end else if (m_fall) begin
            if (k == 0) begin
                if (cap_n == 63) begin
                    got_f.push_back({cap_w[63:1], sdata});
                    got_u.push_back(cap_u);
                end
                cap_n = 0;
                cap_u = underrun;
            end else begin
                cap_w[64 - k] = sdata;
                cap_n++;
            end
        end
    end

    task automatic first_fall();
        int ff;
        bit pb;
        bit lr;
        ff = 0; pb = bck; lr = 1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk); #1;
            if (valid && !ready) valid = 0;
            if (ff == 0 && pb && !bck) begin
                ff = i;
                lr = lrck;
            end
            pb = bck;
        end
        chk("first_fall_clk", ff, 4);
        chk("first_fall_lrck", lr, 0);
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 3000 && !ready; c++) begin
            @(posedge clk); #2;
        end
        chk("wait_ready", ready, 1);
    endtask

    task automatic send(input logic [63:0] w, input logic [1:0] bn);
        wait_ready();
        data = w; bitnum = bn; valid = 1;
        @(posedge clk); #2;
        valid = 0;
    endtask

    task automatic stream();
        logic [63:0] ds[3];
        int idx;
        bit r;
        ds[0] = D0; ds[1] = D1; ds[2] = D2;
        idx = 0;
        data = ds[0]; valid = 1;
        for (int c = 0; c < 3000 && idx < 3; c++) begin
            @(negedge clk); r = ready;
            @(posedge clk); #2;
            if (r) begin
                idx++;
                if (idx == 1) bitnum = B32;
                if (idx < 3) data = ds[idx];
                else valid = 0;
            end
        end
        valid = 0;
        chk("stream_accepts", idx, 3);
    endtask

    initial begin
        logic [63:0] exp_f[10];
        bit          exp_u[10];
        int          n;

        resetn = 0; en = 1; valid = 0; data = '0; bitnum = B32;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_bck", bck, 0);
        chk("rst_lrck", lrck, 1);
        chk("rst_sdata", sdata, 0);
        chk("rst_ready", ready, 1);
        chk("rst_underrun", underrun, 0);

        resetn = 1; data = F0; valid = 1;
        first_fall();

        send(FA, B16);
        send(FA, B24);
        stream();

        // Offer D3 exactly on the load edge of an empty-buffer frame.
        wait_ready();
        for (int c = 0; c < 400 && (m_t % (256 * H / 2) != 3); c++) begin
            @(posedge clk); #2;
        end
        data = D3; valid = 1;
        @(posedge clk); #2;
        valid = 0;

        send(D4, B32);
        wait_ready();
        for (int c = 0; c < 400 && !(m_t > 0 && kof(m_t) == 40); c++) begin
            @(posedge clk); #2;
        end
        chk("abort_k", kof(m_t), 40);
        resetn = 0;
        #1;
        chk("abort_bck", bck, 0);
        chk("abort_lrck", lrck, 1);
        chk("abort_sdata", sdata, 0);
        chk("abort_ready", ready, 1);
        repeat (3) @(posedge clk);
        #2;
        resetn = 1;
        first_fall();

        @(posedge clk); #2;
        en = 0;
        send(D5, B32);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            chk("en_off_bck", bck, 0);
            chk("en_off_ready", ready, 0);
        end
        #1;
        en = 1;

        for (int c = 0; c < 2000 && got_f.size() < 10; c++) @(posedge clk);

        exp_f[0] = F0;                     exp_u[0] = 0;
        exp_f[1] = 64'hFFFF0000_FFFF0000;  exp_u[1] = 0;
        exp_f[2] = 64'hFFFFFF00_FFFFFF00;  exp_u[2] = 0;
        exp_f[3] = D0;                     exp_u[3] = 0;
        exp_f[4] = D1;                     exp_u[4] = 0;
        exp_f[5] = D2;                     exp_u[5] = 0;
        exp_f[6] = 64'h0;                  exp_u[6] = 1;
        exp_f[7] = D3;                     exp_u[7] = 0;
        exp_f[8] = D5;                     exp_u[8] = 0;
        exp_f[9] = 64'h0;                  exp_u[9] = 1;

        chk("frame_count", got_f.size(), 10);
        n = (got_f.size() < 10) ? got_f.size() : 10;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("frame%0d", i), got_f[i], exp_f[i]);
            chk($sformatf("frame%0d_underrun", i), got_u[i], exp_u[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_ser.md
Name: i2s_ser

Overview:
- I2S master transmitter. It is the transmit-side counterpart of i2s_deser.
- Takes 64-bit parallel frames: high word is the left channel, low word is the right channel, each sample MSB-aligned in its 32-bit word.
- Generates bck, lrck and serial data in Philips I2S format, derived from the master clock.
- Used to re-emit processed/loopback audio toward the DAC path or for self-test.

Parameters:
- BCK_HALF, 2, bck half-period in clk cycles (≥1); bck period = 2*BCK_HALF clk.

Ports:
- clk  input  1  master clock (mclk domain)
- resetn  input  1  asynchronous active-low reset
- en  input  1  transmitter enable; low = idle/reset-equivalent (buffer retained)
- data  input  64  frame: [63:32] left, [31:0] right, MSB-aligned samples
- valid  input  1  data valid
- ready  output  1  buffer empty, frame can be accepted
- bitnum  input  BITNUM  sample width (b16/b24/b32, common package)
- bck  output  1  I2S bit clock
- lrck  output  1  word select: 0 = left, 1 = right
- sdata  output  1  serial data, changes on bck falling edge
- underrun  output  1  one-clk pulse when a frame starts with the buffer empty

Behaviour:
- Reset (async, resetn=0):
  - bck=0, lrck=1, sdata=0, ready=1, underrun=0.
  - Slot counter k=63, buffer empty, shift register cleared.
- en=0: same state as reset, applied synchronously, except the buffer and its contents are kept. ready reflects the buffer state.
- bck generation: a divider counts clk cycles 0..BCK_HALF-1 and toggles bck on wrap. The first rise occurs BCK_HALF clk after reset release or after en rises; the first fall occurs at 2*BCK_HALF.
- Slot counter k (6 bits, 0..63) advances on each bck falling edge (the clk cycle where bck goes 1→0), wrapping 63→0.
- Registered outputs update in the same clk cycle as the falling edge:
  - lrck = 0 for k=0..31, 1 for k=32..63.
  - sdata, one-bit I2S delay. For frame F, with L/R the masked words:
    - k=0: R(F-1)[0]
    - k=1..32: L(F)[32-k], i.e. MSB at k=1, bit0 at k=32
    - k=33..63: R(F)[64-k], i.e. bit31 at k=33, bit1 at k=63
  - The first frame after reset uses R(F-1)=0.
- Frame load happens on the falling edge where k becomes 0:
  - Buffer full: the word is transferred to the shift register, masked by bitnum sampled at that cycle. Masking: b16 zeroes bits [15:0] of each word, b24 zeroes [7:0], b32 applies no mask. The buffer becomes empty and ready rises the next clk.
  - Buffer empty: frame F is all zeros, and underrun is high for exactly one clk (that cycle).
- Handshake: a frame is accepted on a clk rising edge when valid&&ready. The buffer then becomes full and ready=0 from the next clk. valid with ready=0 is ignored; there is no backpressure on the source beyond ready.
- Simultaneous acceptance and frame load (buffer empty at load while valid&&ready): there is no bypass. The underrun fires, frame F is zeros, and the accepted word is sent in frame F+1.
- bitnum changes mid-frame have no effect until the next frame load.
- Reset or en=0 mid-frame aborts the frame; the next frame restarts at k=0 with left first.

Test Plan:
- Basic frame, BCK_HALF=2, b32:
  - Stimulus: after reset, present data=64'hA5000001_80000003 with valid before the first bck fall.
  - Required: first bck fall at clk 4 after reset release, lrck falls there.
  - Required: sdata at k=1..32 = A5000001 MSB-first, k=33..63 = 80000003 bits 31..1, next frame k=0 = 1.
- Masking:
  - Stimulus: bitnum=b16, data=64'hFFFFFFFF_FFFFFFFF.
  - Required: sdata is 1 for left bits 31..16 and right bits 31..16, 0 for bits 15..0.
  - Stimulus: b24 with the same data.
  - Required: only bits 7..0 are 0.
- Underrun:
  - Stimulus: no valid before the first load.
  - Required: underrun is one 1-clk pulse at k→0 and frame sdata is all zeros.
  - Stimulus: valid asserted in that same cycle.
  - Required: the word appears in the following frame.
- Backpressure:
  - Stimulus: valid held high with successive values D0,D1,D2.
  - Required: ready=0 while full, exactly one accept per frame, output frames D0,D1,D2 in order with no underrun.
- Mid-frame reset:
  - Stimulus: assert resetn=0 at k=40.
  - Required: outputs immediately go bck=0, lrck=1, sdata=0, ready=1; after release the first fall is at clk 4 with k=0.
- Enable gating:
  - Stimulus: en=0 for 100 clk with the buffer full.
  - Required: bck stays 0 and ready stays 0.
  - Stimulus: en back to 1.
  - Required: the buffered frame is sent as the first frame.
